// File: rtl/leddc_frame_serializer.sv
// Serializes 16-bit grayscale words into the LEDDC DCK-domain DAI/DEN stream, framed in WORDS_PER_FRAME words.
// Optional build macro LEDDC_SER_ABORT_EN adds a frame_abort input that ends the current frame early.
module leddc_frame_serializer #(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned WORDS_PER_FRAME = 512,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned FRAME_GAP       = 3,
    localparam int unsigned IDX_W          = $clog2(WORDS_PER_FRAME)
) (
    input  logic              DCK,
    input  logic              rst,
`ifdef LEDDC_SER_ABORT_EN
    input  logic              frame_abort,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              DAI,
    output logic              DEN,
    output logic [IDX_W-1:0]  word_idx,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned MAX_GAP = (GAP_CYCLES > FRAME_GAP) ? GAP_CYCLES : FRAME_GAP;
    localparam int unsigned CNT_W   = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FGAP_LAST = CNT_W'(FRAME_GAP - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_FGAP  = 2'd3;

    logic [1:0]        state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [CNT_W-1:0]  gap_cnt, gap_cnt_d;
    logic [IDX_W-1:0]  word_idx_d;
    logic              aborted, aborted_d;
    logic              den_d, dai_d, frame_done_d;
    logic              abort_req;

`ifdef LEDDC_SER_ABORT_EN
    assign abort_req = frame_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Next-state and next-output decode; DEN/DAI default low so DAI is never driven while DEN is low.
    always_comb begin
        state_d      = state;
        shreg_d      = shreg;
        bit_cnt_d    = bit_cnt;
        gap_cnt_d    = gap_cnt;
        word_idx_d   = word_idx;
        aborted_d    = aborted;
        den_d        = 1'b0;
        dai_d        = 1'b0;
        frame_done_d = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    den_d     = 1'b1;
                    dai_d     = in_data[0];
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    gap_cnt_d = '0;
                    if (word_idx == LAST_WORD) begin
                        state_d = ST_FGAP;
                    end else begin
                        word_idx_d = word_idx + IDX_W'(1);
                        state_d    = ST_GAP;
                    end
                end else begin
                    shreg_d   = shreg >> 1;
                    den_d     = 1'b1;
                    dai_d     = shreg[1];
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (gap_cnt == FGAP_LAST) begin
                    state_d    = ST_IDLE;
                    word_idx_d = '0;
                    aborted_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt + CNT_W'(1);
                end
            end
        endcase

        // Abort overrides any handshake or shift in progress and suppresses frame_done for this frame.
        if (abort_req) begin
            state_d    = ST_FGAP;
            gap_cnt_d  = '0;
            word_idx_d = '0;
            aborted_d  = 1'b1;
            den_d      = 1'b0;
            dai_d      = 1'b0;
        end

        frame_done_d = (state_d == ST_FGAP) && (gap_cnt_d == FGAP_LAST) && !aborted_d;
    end

    always_ff @(posedge DCK) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            word_idx   <= '0;
            aborted    <= 1'b0;
            DEN        <= 1'b0;
            DAI        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            word_idx   <= word_idx_d;
            aborted    <= aborted_d;
            DEN        <= den_d;
            DAI        <= dai_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_leddc_frame_serializer.sv
// Directed bench for leddc_frame_serializer; abort steps build only with LEDDC_SER_ABORT_EN.
module tb_leddc_frame_serializer;

    logic        DCK = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        DAI;
    logic        DEN;
    logic [8:0]  word_idx;
    logic        frame_done;
    logic        busy;
`ifdef LEDDC_SER_ABORT_EN
    logic        frame_abort;
`endif

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    leddc_frame_serializer dut (
        .DCK        (DCK),
        .rst        (rst),
`ifdef LEDDC_SER_ABORT_EN
        .frame_abort(frame_abort),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .DAI        (DAI),
        .DEN        (DEN),
        .word_idx   (word_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 DCK = ~DCK;

    always @(negedge DCK) if (frame_done) fd_count <= fd_count + 1;

    task automatic tick();
        @(posedge DCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the serializer to return to IDLE.
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("wait_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] cap;
        logic        den_all;
        int          fd_before;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
`ifdef LEDDC_SER_ABORT_EN
        frame_abort = 1'b0;
`endif
        tick();
        rst = 1'b0;
        check("rst_den", 32'(DEN), 32'd0);
        check("rst_dai", 32'(DAI), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_idx", 32'(word_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);

        // Single word A5C3, LSB first; in_data changes during SHIFT must be ignored
        pat = 16'hA5C3;
        in_valid = 1'b1; in_data = pat;
        tick();
        in_valid = 1'b0; in_data = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            check("a5c3_den", 32'(DEN), 32'd1);
            check("a5c3_dai", 32'(DAI), 32'(pat[k]));
            tick();
        end
        check("a5c3_gap1_den", 32'(DEN), 32'd0);
        check("a5c3_gap1_dai", 32'(DAI), 32'd0);
        check("a5c3_gap1_busy", 32'(busy), 32'd1);
        check("a5c3_gap1_ready", 32'(in_ready), 32'd0);
        check("a5c3_idx", 32'(word_idx), 32'd1);
        tick();
        check("a5c3_gap2_den", 32'(DEN), 32'd0);
        check("a5c3_gap2_busy", 32'(busy), 32'd1);
        tick();
        check("a5c3_idle_ready", 32'(in_ready), 32'd1);
        check("a5c3_idle_busy", 32'(busy), 32'd0);

        // Back-to-back 0001 then 8000 with in_valid held: second burst starts 19 cycles later
        in_valid = 1'b1; in_data = 16'h0001;
        tick();
        in_data = 16'h8000;
        for (int c = 0; c < 35; c++) begin
            check("b2b_den", 32'(DEN), 32'((c < 16) || (c >= 19)));
            check("b2b_dai", 32'(DAI), 32'((c == 0) || (c == 34)));
            if (c == 19) in_valid = 1'b0;
            tick();
        end
        check("b2b_end_den", 32'(DEN), 32'd0);
        check("b2b_idx", 32'(word_idx), 32'd3);

        // 50 idle cycles mid-frame
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_den", 32'(DEN), 32'd0);
            check("idle_dai", 32'(DAI), 32'd0);
            check("idle_idx", 32'(word_idx), 32'd3);
            check("idle_busy", 32'(busy), 32'(i == 0));
        end

        // Reset during DEN cycle 7 of word 5
        for (int w = 3; w < 5; w++) begin
            in_valid = 1'b1; in_data = 16'(w);
            tick();
            in_valid = 1'b0;
            wait_ready();
        end
        in_valid = 1'b1; in_data = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        check("w5_idx", 32'(word_idx), 32'd5);
        repeat (7) tick();
        check("w5_cyc7_den", 32'(DEN), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_den", 32'(DEN), 32'd0);
        check("midrst_dai", 32'(DAI), 32'd0);
        check("midrst_idx", 32'(word_idx), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        in_valid = 1'b1; in_data = 16'h0006;
        tick();
        in_valid = 1'b0;
        check("post_rst_b0", 32'({DEN, DAI}), 32'b10);
        tick();
        check("post_rst_b1", 32'({DEN, DAI}), 32'b11);
        tick();
        check("post_rst_b2", 32'({DEN, DAI}), 32'b11);
        tick();
        check("post_rst_b3", 32'({DEN, DAI}), 32'b10);
        wait_ready();

        // Full frame of 512 words carrying their own index
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fd_before = fd_count;
        for (int i = 0; i < 512; i++) begin
            check("frm_idx", 32'(word_idx), 32'(i));
            in_valid = 1'b1; in_data = 16'(i);
            tick();
            in_valid = 1'b0;
            den_all = 1'b1;
            for (int k = 0; k < 16; k++) begin
                den_all = den_all & DEN;
                cap[k] = DAI;
                tick();
            end
            check("frm_den", 32'(den_all), 32'd1);
            check("frm_word", 32'(cap), 32'(i));
            if (i < 511) wait_ready();
        end
        check("fgap0_den", 32'(DEN), 32'd0);
        check("fgap0_done", 32'(frame_done), 32'd0);
        check("fgap0_idx", 32'(word_idx), 32'd511);
        check("fgap0_busy", 32'(busy), 32'd1);
        tick();
        check("fgap1_den", 32'(DEN), 32'd0);
        check("fgap1_done", 32'(frame_done), 32'd0);
        tick();
        check("fgap2_den", 32'(DEN), 32'd0);
        check("fgap2_done", 32'(frame_done), 32'd1);
        tick();
        check("fend_done", 32'(frame_done), 32'd0);
        check("fend_idx", 32'(word_idx), 32'd0);
        check("fend_ready", 32'(in_ready), 32'd1);
        check("fend_pulses", 32'(fd_count - fd_before), 32'd1);

`ifdef LEDDC_SER_ABORT_EN
        // Abort at word 100 bit 3, then abort in IDLE rejects a valid word
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fd_before = fd_count;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            tick();
            in_valid = 1'b0;
            wait_ready();
        end
        check("ab_idx100", 32'(word_idx), 32'd100);
        in_valid = 1'b1; in_data = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("ab_bit3_den", 32'(DEN), 32'd1);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        check("ab_den", 32'(DEN), 32'd0);
        check("ab_dai", 32'(DAI), 32'd0);
        check("ab_idx", 32'(word_idx), 32'd0);
        check("ab_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("ab_fgap_done", 32'(frame_done), 32'd0);
            check("ab_fgap_den", 32'(DEN), 32'd0);
            tick();
        end
        check("ab_end_ready", 32'(in_ready), 32'd1);
        check("ab_end_idx", 32'(word_idx), 32'd0);
        check("ab_no_pulse", 32'(fd_count - fd_before), 32'd0);
        in_valid = 1'b1; frame_abort = 1'b1; in_data = 16'h1234;
        tick();
        in_valid = 1'b0; frame_abort = 1'b0;
        check("ab_idle_den", 32'(DEN), 32'd0);
        check("ab_idle_busy", 32'(busy), 32'd1);
        check("ab_idle_ready", 32'(in_ready), 32'd0);
        wait_ready();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
